// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and helpers for the pipelined RV32I control path.
//   ctrl_bundle_t : decoded control carried from D into E.
//   mem_ctrl_t    : the subset of control still needed in M.
//   wb_ctrl_t     : the subset of control still needed in W.
//   result_src_e, pc_src_e, fwd_sel_e : encodings of the mux selects.
//   F3_BEQ..F3_BGEU : branch funct3 codes.
// The bundle field widths come from the PKG_* localparams below; the
// ctrl_pipeline width parameters default to these values and must match
// them (widen here first if a wider configuration is ever needed).
package ctrl_pkg;

  localparam int PKG_REG_ADDR_W = 5;
  localparam int PKG_CTRL_W     = 4;
  localparam int PKG_REGW_W     = 3;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10
  } result_src_e;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_TARGET = 2'b01,
    PC_ALU    = 2'b10
  } pc_src_e;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_W    = 2'b01,
    FWD_M    = 2'b10
  } fwd_sel_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // result_src is kept as raw bits: the 2'b11 code can appear on the wire
  // and must travel down the pipe unchanged.
  typedef struct packed {
    logic [PKG_REGW_W-1:0]     reg_write;
    logic [1:0]                result_src;
    logic [1:0]                mem_write;
    logic                      jump;
    logic                      jalr;
    logic                      branch;
    logic [PKG_CTRL_W-1:0]     alu_control;
    logic                      alu_src;
    logic [2:0]                funct3;
    logic [PKG_REG_ADDR_W-1:0] rs1;
    logic [PKG_REG_ADDR_W-1:0] rs2;
    logic [PKG_REG_ADDR_W-1:0] rd;
  } ctrl_bundle_t;

  typedef struct packed {
    logic [PKG_REGW_W-1:0]     reg_write;
    logic [1:0]                result_src;
    logic [1:0]                mem_write;
    logic [PKG_REG_ADDR_W-1:0] rd;
  } mem_ctrl_t;

  typedef struct packed {
    logic [PKG_REGW_W-1:0]     reg_write;
    logic [1:0]                result_src;
    logic [PKG_REG_ADDR_W-1:0] rd;
  } wb_ctrl_t;

  // Condition of a conditional branch from the E-stage ALU flags.
  // funct3 010/011 are not branch encodings and never take.
  function automatic logic branch_taken(input logic [2:0] funct3,
                                        input logic zero,
                                        input logic lt,
                                        input logic ltu);
    logic taken;
    case (funct3)
      F3_BEQ:  taken = zero;
      F3_BNE:  taken = !zero;
      F3_BLT:  taken = lt;
      F3_BGE:  taken = !lt;
      F3_BLTU: taken = ltu;
      F3_BGEU: taken = !ltu;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

  // A stage "produces" rs when it writes a nonzero destination equal to rs.
  // x0 never matches, so it never forwards and never stalls.
  function automatic logic dest_hits(input logic [PKG_REGW_W-1:0]     reg_write,
                                     input logic [PKG_REG_ADDR_W-1:0] rd,
                                     input logic [PKG_REG_ADDR_W-1:0] rs);
    return (reg_write != '0) && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/ctrl_pipeline_hazard_unit.sv
// hazard_unit: forwarding selects and stall/flush generation.
// Ports:
//   rs1_d, rs2_d            source registers of the instruction in D
//   rs1_e, rs2_e            source registers of the instruction in E
//   rd_e/m/w, reg_write_e/m/w  destination and write enable per stage
//   result_src_e            E-stage result select (01 = load)
//   redirect                E stage is changing the PC this cycle
//   forward_a, forward_b    00 regfile, 01 W result, 10 M ALU result
//   stall_f, stall_d        hold PC and F/D register
//   flush_d, flush_e        bubble F/D and D/E registers
// Purely combinational.
module hazard_unit
  import ctrl_pkg::*;
#(
  parameter bit FWD_EN = 1'b1
) (
  input  logic [PKG_REG_ADDR_W-1:0] rs1_d,
  input  logic [PKG_REG_ADDR_W-1:0] rs2_d,
  input  logic [PKG_REG_ADDR_W-1:0] rs1_e,
  input  logic [PKG_REG_ADDR_W-1:0] rs2_e,
  input  logic [PKG_REG_ADDR_W-1:0] rd_e,
  input  logic [PKG_REG_ADDR_W-1:0] rd_m,
  input  logic [PKG_REG_ADDR_W-1:0] rd_w,
  input  logic [PKG_REGW_W-1:0]     reg_write_e,
  input  logic [PKG_REGW_W-1:0]     reg_write_m,
  input  logic [PKG_REGW_W-1:0]     reg_write_w,
  input  logic [1:0]                result_src_e,
  input  logic                      redirect,
  output logic [1:0]                forward_a,
  output logic [1:0]                forward_b,
  output logic                      stall_f,
  output logic                      stall_d,
  output logic                      flush_d,
  output logic                      flush_e
);

  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;
  logic       load_use;
  logic       raw_any;
  logic       hazard;

  // M is younger than W, so its value wins when both match.
  always_comb begin
    fwd_a_sel = FWD_NONE;
    fwd_b_sel = FWD_NONE;
    if (dest_hits(reg_write_m, rd_m, rs1_e))      fwd_a_sel = FWD_M;
    else if (dest_hits(reg_write_w, rd_w, rs1_e)) fwd_a_sel = FWD_W;
    if (dest_hits(reg_write_m, rd_m, rs2_e))      fwd_b_sel = FWD_M;
    else if (dest_hits(reg_write_w, rd_w, rs2_e)) fwd_b_sel = FWD_W;
  end

  // With forwarding only a load in E is too late to bypass to D.
  assign load_use = (result_src_e == RES_LOAD) && (rd_e != '0) &&
                    ((rd_e == rs1_d) || (rd_e == rs2_d));

  // Without forwarding any in-flight producer of a D source blocks D.
  assign raw_any = dest_hits(reg_write_e, rd_e, rs1_d) || dest_hits(reg_write_e, rd_e, rs2_d) ||
                   dest_hits(reg_write_m, rd_m, rs1_d) || dest_hits(reg_write_m, rd_m, rs2_d) ||
                   dest_hits(reg_write_w, rd_w, rs1_d) || dest_hits(reg_write_w, rd_w, rs2_d);

  assign hazard    = FWD_EN ? load_use : raw_any;
  assign forward_a = FWD_EN ? fwd_a_sel : FWD_NONE;
  assign forward_b = FWD_EN ? fwd_b_sel : FWD_NONE;

  // A redirect kills the stalled instruction anyway, so it overrides the stall.
  assign stall_f = hazard && !redirect;
  assign stall_d = hazard && !redirect;
  assign flush_d = redirect;
  assign flush_e = redirect || hazard;

endmodule

// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline: pipelined control path for the 5-stage RV32I core.
// Carries decoded control D -> E -> M -> W, resolves branches and jumps in E,
// and drives forwarding selects and stall/flush through hazard_unit.
// Ports:
//   clk, rst                 clock; synchronous active-low reset
//   *D inputs                decoded control and register indices of the D instruction
//   ZeroE, LtE, LtuE         ALU flags of the E instruction
//   ALUControlE, ALUSrcE     E-stage ALU controls
//   MemWriteM                M-stage store control
//   RegWriteW, ResultSrcW, RdW  W-stage writeback controls
//   PCSrcE                   00 PC+4, 01 PC+imm, 10 ALU result
//   ForwardAE, ForwardBE     00 regfile, 01 W result, 10 M ALU result
//   StallF, StallD, FlushD, FlushE  hazard controls
// Hazard and branch outputs are combinational from the pipeline registers
// (plus the D register indices); nothing in D reaches a W output without
// passing through three registers.
module ctrl_pipeline
  import ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = PKG_REG_ADDR_W,
  parameter int CTRL_W     = PKG_CTRL_W,
  parameter int REGW_W     = PKG_REGW_W,
  parameter bit FWD_EN     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REGW_W-1:0]     RegWriteD,
  input  logic [1:0]            ResultSrcD,
  input  logic [1:0]            MemWriteD,
  input  logic                  JumpD,
  input  logic                  JalrD,
  input  logic                  BranchD,
  input  logic [CTRL_W-1:0]     ALUControlD,
  input  logic                  ALUSrcD,
  input  logic [2:0]            funct3D,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] RdD,
  input  logic                  ZeroE,
  input  logic                  LtE,
  input  logic                  LtuE,
  output logic [CTRL_W-1:0]     ALUControlE,
  output logic                  ALUSrcE,
  output logic [1:0]            MemWriteM,
  output logic [REGW_W-1:0]     RegWriteW,
  output logic [1:0]            ResultSrcW,
  output logic [REG_ADDR_W-1:0] RdW,
  output logic [1:0]            PCSrcE,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  FlushD,
  output logic                  FlushE
);

  ctrl_bundle_t bundle_d;
  ctrl_bundle_t stage_e;
  mem_ctrl_t    stage_m;
  wb_ctrl_t     stage_w;
  pc_src_e      pc_src;
  logic         taken_e;
  logic         flush_e;

  always_comb begin
    bundle_d             = '0;
    bundle_d.reg_write   = PKG_REGW_W'(RegWriteD);
    bundle_d.result_src  = ResultSrcD;
    bundle_d.mem_write   = MemWriteD;
    bundle_d.jump        = JumpD;
    bundle_d.jalr        = JalrD;
    bundle_d.branch      = BranchD;
    bundle_d.alu_control = PKG_CTRL_W'(ALUControlD);
    bundle_d.alu_src     = ALUSrcD;
    bundle_d.funct3      = funct3D;
    bundle_d.rs1         = PKG_REG_ADDR_W'(Rs1D);
    bundle_d.rs2         = PKG_REG_ADDR_W'(Rs2D);
    bundle_d.rd          = PKG_REG_ADDR_W'(RdD);
  end

  // D/E takes a bubble on flush; the held F/D contents keep feeding the
  // D inputs during a stall, so no separate hold path is needed here.
  // E/M and M/W always advance.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stage_e <= '0;
      stage_m <= '0;
      stage_w <= '0;
    end else begin
      if (flush_e) stage_e <= '0;
      else         stage_e <= bundle_d;
      stage_m <= '{reg_write:  stage_e.reg_write,
                   result_src: stage_e.result_src,
                   mem_write:  stage_e.mem_write,
                   rd:         stage_e.rd};
      stage_w <= '{reg_write:  stage_m.reg_write,
                   result_src: stage_m.result_src,
                   rd:         stage_m.rd};
    end
  end

  // JALR beats JAL beats a taken branch.
  always_comb begin
    taken_e = stage_e.branch && branch_taken(stage_e.funct3, ZeroE, LtE, LtuE);
    pc_src  = PC_PLUS4;
    if (stage_e.jalr)                    pc_src = PC_ALU;
    else if (stage_e.jump || taken_e)    pc_src = PC_TARGET;
  end

  hazard_unit #(.FWD_EN(FWD_EN)) u_hazard (
    .rs1_d        (bundle_d.rs1),
    .rs2_d        (bundle_d.rs2),
    .rs1_e        (stage_e.rs1),
    .rs2_e        (stage_e.rs2),
    .rd_e         (stage_e.rd),
    .rd_m         (stage_m.rd),
    .rd_w         (stage_w.rd),
    .reg_write_e  (stage_e.reg_write),
    .reg_write_m  (stage_m.reg_write),
    .reg_write_w  (stage_w.reg_write),
    .result_src_e (stage_e.result_src),
    .redirect     (pc_src != PC_PLUS4),
    .forward_a    (ForwardAE),
    .forward_b    (ForwardBE),
    .stall_f      (StallF),
    .stall_d      (StallD),
    .flush_d      (FlushD),
    .flush_e      (flush_e)
  );

  assign FlushE      = flush_e;
  assign PCSrcE      = pc_src;
  assign ALUControlE = CTRL_W'(stage_e.alu_control);
  assign ALUSrcE     = stage_e.alu_src;
  assign MemWriteM   = stage_m.mem_write;
  assign RegWriteW   = REGW_W'(stage_w.reg_write);
  assign ResultSrcW  = stage_w.result_src;
  assign RdW         = REG_ADDR_W'(stage_w.rd);

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Bench for ctrl_pipeline. Two instances run side by side:
//   index 0: FWD_EN=0 (stall on every RAW hazard), index 1: FWD_EN=1.
// The bench plays fetch/decode (honours StallD/FlushD) and the datapath
// (derives ALU flags from per-instruction operand values). Expected outputs
// for each cycle come from an instruction-level model of the pipe and are
// queued; a negedge monitor pops and compares every output field.
module tb_ctrl_pipeline;

  typedef struct packed {
    logic [2:0]  rw;
    logic [1:0]  rsrc;
    logic [1:0]  mw;
    logic        jump;
    logic        jalr;
    logic        branch;
    logic [3:0]  aluc;
    logic        alusrc;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] opa;
    logic [31:0] opb;
  } instr_t;

  typedef struct packed {
    logic [3:0] alu_ctrl_e;
    logic       alu_src_e;
    logic [1:0] mem_write_m;
    logic [2:0] reg_write_w;
    logic [1:0] result_src_w;
    logic [4:0] rd_w;
    logic [1:0] pc_src_e;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       stall_f;
    logic       stall_d;
    logic       flush_d;
    logic       flush_e;
  } out_t;

  localparam int OUT_W    = $bits(out_t);
  localparam int PROG_MAX = 40;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  instr_t     d_in [2];
  logic       zero_e [2];
  logic       lt_e [2];
  logic       ltu_e [2];
  logic [3:0] alu_ctrl_e [2];
  logic       alu_src_e [2];
  logic [1:0] mem_write_m [2];
  logic [2:0] reg_write_w [2];
  logic [1:0] result_src_w [2];
  logic [4:0] rd_w [2];
  logic [1:0] pc_src_e [2];
  logic [1:0] fwd_a [2];
  logic [1:0] fwd_b [2];
  logic       stall_f [2];
  logic       stall_d [2];
  logic       flush_d [2];
  logic       flush_e [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ctrl_pipeline #(.FWD_EN(bit'(g == 1))) dut (
      .clk         (clk),
      .rst         (rst),
      .RegWriteD   (d_in[g].rw),
      .ResultSrcD  (d_in[g].rsrc),
      .MemWriteD   (d_in[g].mw),
      .JumpD       (d_in[g].jump),
      .JalrD       (d_in[g].jalr),
      .BranchD     (d_in[g].branch),
      .ALUControlD (d_in[g].aluc),
      .ALUSrcD     (d_in[g].alusrc),
      .funct3D     (d_in[g].f3),
      .Rs1D        (d_in[g].rs1),
      .Rs2D        (d_in[g].rs2),
      .RdD         (d_in[g].rd),
      .ZeroE       (zero_e[g]),
      .LtE         (lt_e[g]),
      .LtuE        (ltu_e[g]),
      .ALUControlE (alu_ctrl_e[g]),
      .ALUSrcE     (alu_src_e[g]),
      .MemWriteM   (mem_write_m[g]),
      .RegWriteW   (reg_write_w[g]),
      .ResultSrcW  (result_src_w[g]),
      .RdW         (rd_w[g]),
      .PCSrcE      (pc_src_e[g]),
      .ForwardAE   (fwd_a[g]),
      .ForwardBE   (fwd_b[g]),
      .StallF      (stall_f[g]),
      .StallD      (stall_d[g]),
      .FlushD      (flush_d[g]),
      .FlushE      (flush_e[g])
    );
  end

  // ---------------- model state ----------------
  instr_t           st [2][3];          // instruction in E, M, W
  logic             last_flush_d [2];
  logic             last_flush_e [2];
  logic             last_stall_d [2];
  instr_t           prog [2][PROG_MAX];
  int               prog_len [2];
  int               prog_idx [2];
  bit               wr_heavy;
  logic [OUT_W-1:0] exp_q0[$];
  logic [OUT_W-1:0] exp_q1[$];
  int               n_checks;
  int               n_fail;

  // ---------------- instruction builders ----------------
  function automatic instr_t op_alu(input int rd, input int rs1, input int rs2, input int aluc);
    instr_t i = '0;
    i.rw = 3'd1; i.rd = 5'(rd); i.rs1 = 5'(rs1); i.rs2 = 5'(rs2); i.aluc = 4'(aluc);
    return i;
  endfunction

  function automatic instr_t op_lw(input int rd, input int rs1);
    instr_t i = '0;
    i.rw = 3'd1; i.rsrc = 2'b01; i.alusrc = 1'b1; i.rd = 5'(rd); i.rs1 = 5'(rs1);
    return i;
  endfunction

  function automatic instr_t op_br(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    instr_t i = '0;
    i.branch = 1'b1; i.f3 = f3; i.opa = a; i.opb = b; i.rs1 = 5'd1; i.rs2 = 5'd2;
    return i;
  endfunction

  function automatic instr_t rand_instr(input bit heavy);
    instr_t i;
    i.rw     = ($urandom_range(0, 3) == 0 && !heavy) ? 3'd0 : 3'($urandom_range(1, 7));
    i.rsrc   = 2'($urandom_range(0, 2));
    i.mw     = 2'($urandom_range(0, 3));
    i.jump   = !heavy && ($urandom_range(0, 9) == 0);
    i.jalr   = !heavy && ($urandom_range(0, 11) == 0);
    i.branch = !heavy && ($urandom_range(0, 3) == 0);
    i.aluc   = 4'($urandom_range(0, 15));
    i.alusrc = 1'($urandom_range(0, 1));
    i.f3     = 3'($urandom_range(0, 7));
    i.rs1    = 5'($urandom_range(0, 7));
    i.rs2    = 5'($urandom_range(0, 7));
    i.rd     = heavy ? 5'($urandom_range(1, 7)) : 5'($urandom_range(0, 7));
    i.opa    = $urandom;
    i.opb    = ($urandom_range(0, 3) == 0) ? i.opa : $urandom;
    return i;
  endfunction

  // ---------------- reference rules ----------------
  function automatic bit cond_met(input instr_t i);
    case (i.f3)
      3'b000:  return i.opa == i.opb;
      3'b001:  return i.opa != i.opb;
      3'b100:  return $signed(i.opa) <  $signed(i.opb);
      3'b101:  return $signed(i.opa) >= $signed(i.opb);
      3'b110:  return i.opa <  i.opb;
      3'b111:  return i.opa >= i.opb;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit writes(input instr_t i, input logic [4:0] r);
    return (i.rw != 3'd0) && (i.rd != 5'd0) && (i.rd == r);
  endfunction

  function automatic out_t predict(input int k);
    instr_t e, m, w, d;
    out_t   o;
    bit     haz;
    bit     redirect;
    e = st[k][0]; m = st[k][1]; w = st[k][2]; d = d_in[k];
    o = '0;
    o.alu_ctrl_e   = e.aluc;
    o.alu_src_e    = e.alusrc;
    o.mem_write_m  = m.mw;
    o.reg_write_w  = w.rw;
    o.result_src_w = w.rsrc;
    o.rd_w         = w.rd;
    if (e.jalr)                              o.pc_src_e = 2'b10;
    else if (e.jump || (e.branch && cond_met(e))) o.pc_src_e = 2'b01;
    else                                     o.pc_src_e = 2'b00;
    redirect = (o.pc_src_e != 2'b00);
    if (k == 1) begin
      o.fwd_a = writes(m, e.rs1) ? 2'b10 : (writes(w, e.rs1) ? 2'b01 : 2'b00);
      o.fwd_b = writes(m, e.rs2) ? 2'b10 : (writes(w, e.rs2) ? 2'b01 : 2'b00);
      haz = (e.rsrc == 2'b01) && (e.rd != 5'd0) && ((e.rd == d.rs1) || (e.rd == d.rs2));
    end else begin
      haz = writes(e, d.rs1) || writes(e, d.rs2) || writes(m, d.rs1) ||
            writes(m, d.rs2) || writes(w, d.rs1) || writes(w, d.rs2);
    end
    o.stall_f = haz && !redirect;
    o.stall_d = haz && !redirect;
    o.flush_d = redirect;
    o.flush_e = redirect || haz;
    return o;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic next_instr(input int k, output instr_t i);
    if (prog_idx[k] < prog_len[k]) begin
      i = prog[k][prog_idx[k]];
      prog_idx[k]++;
    end else begin
      i = rand_instr(wr_heavy);
    end
  endtask

  // Applies the effect of the clock edge that just happened to the model,
  // then presents the new D instruction and E flags.
  task automatic advance(input int k);
    instr_t nxt;
    if (!rst) begin
      for (int s = 0; s < 3; s++) st[k][s] = '0;
      d_in[k] = '0;
    end else begin
      st[k][2] = st[k][1];
      st[k][1] = st[k][0];
      st[k][0] = last_flush_e[k] ? instr_t'('0) : d_in[k];
      if (last_flush_d[k]) d_in[k] = '0;
      else if (!last_stall_d[k]) begin
        next_instr(k, nxt);
        d_in[k] = nxt;
      end
    end
  endtask

  task automatic drive_and_predict(input int k);
    out_t o;
    zero_e[k] = (st[k][0].opa == st[k][0].opb);
    lt_e[k]   = ($signed(st[k][0].opa) < $signed(st[k][0].opb));
    ltu_e[k]  = (st[k][0].opa < st[k][0].opb);
    o = predict(k);
    last_flush_d[k] = o.flush_d;
    last_flush_e[k] = o.flush_e;
    last_stall_d[k] = o.stall_d;
    if (k == 0) exp_q0.push_back(o);
    else        exp_q1.push_back(o);
  endtask

  task automatic run_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        advance(k);
        drive_and_predict(k);
      end
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic check(input int k, input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d t=%0t got %0h expected %0h", name, k, $time, act, exp);
    end
  endtask

  task automatic compare(input int k, input logic [OUT_W-1:0] raw);
    out_t e;
    e = out_t'(raw);
    check(k, "ALUControlE", 8'(alu_ctrl_e[k]),   8'(e.alu_ctrl_e));
    check(k, "ALUSrcE",     8'(alu_src_e[k]),    8'(e.alu_src_e));
    check(k, "MemWriteM",   8'(mem_write_m[k]),  8'(e.mem_write_m));
    check(k, "RegWriteW",   8'(reg_write_w[k]),  8'(e.reg_write_w));
    check(k, "ResultSrcW",  8'(result_src_w[k]), 8'(e.result_src_w));
    check(k, "RdW",         8'(rd_w[k]),         8'(e.rd_w));
    check(k, "PCSrcE",      8'(pc_src_e[k]),     8'(e.pc_src_e));
    check(k, "ForwardAE",   8'(fwd_a[k]),        8'(e.fwd_a));
    check(k, "ForwardBE",   8'(fwd_b[k]),        8'(e.fwd_b));
    check(k, "StallF",      8'(stall_f[k]),      8'(e.stall_f));
    check(k, "StallD",      8'(stall_d[k]),      8'(e.stall_d));
    check(k, "FlushD",      8'(flush_d[k]),      8'(e.flush_d));
    check(k, "FlushE",      8'(flush_e[k]),      8'(e.flush_e));
  endtask

  always @(negedge clk) begin
    if (exp_q0.size() > 0) compare(0, exp_q0.pop_front());
    if (exp_q1.size() > 0) compare(1, exp_q1.pop_front());
  end

  // ---------------- directed programs ----------------
  task automatic load_programs();
    instr_t nop = '0;
    instr_t j;
    prog_len[0] = 0; prog_len[1] = 0; prog_idx[0] = 0; prog_idx[1] = 0;
    // FWD_EN=1: forward from M, from W, x0 destination, load-use,
    // BGE taken / not taken, funct3 010, JALR over a load-use hazard.
    prog[1][prog_len[1]++] = op_alu(5, 1, 2, 0);
    prog[1][prog_len[1]++] = op_alu(6, 5, 3, 1);
    prog[1][prog_len[1]++] = nop;
    prog[1][prog_len[1]++] = op_alu(5, 1, 2, 0);
    prog[1][prog_len[1]++] = nop;
    prog[1][prog_len[1]++] = op_alu(6, 5, 3, 1);
    prog[1][prog_len[1]++] = nop;
    prog[1][prog_len[1]++] = op_alu(0, 1, 2, 0);
    prog[1][prog_len[1]++] = op_alu(6, 0, 3, 1);
    prog[1][prog_len[1]++] = nop;
    prog[1][prog_len[1]++] = nop;
    prog[1][prog_len[1]++] = op_lw(5, 1);
    prog[1][prog_len[1]++] = op_alu(6, 5, 2, 0);
    prog[1][prog_len[1]++] = nop;
    prog[1][prog_len[1]++] = op_br(3'b101, 32'd5, 32'd3);
    prog[1][prog_len[1]++] = nop;
    prog[1][prog_len[1]++] = op_br(3'b101, 32'hFFFF_FFFF, 32'd3);
    prog[1][prog_len[1]++] = nop;
    prog[1][prog_len[1]++] = op_br(3'b010, 32'd7, 32'd7);
    prog[1][prog_len[1]++] = nop;
    j = op_lw(7, 1);
    j.jalr = 1'b1;
    prog[1][prog_len[1]++] = j;
    prog[1][prog_len[1]++] = op_alu(8, 7, 2, 0);
    prog[1][prog_len[1]++] = nop;
    // FWD_EN=0: back-to-back dependency stalls three cycles; x0 never stalls.
    prog[0][prog_len[0]++] = op_alu(5, 1, 2, 0);
    prog[0][prog_len[0]++] = op_alu(6, 5, 2, 0);
    prog[0][prog_len[0]++] = nop;
    prog[0][prog_len[0]++] = op_alu(0, 1, 2, 0);
    prog[0][prog_len[0]++] = op_alu(6, 0, 0, 0);
    prog[0][prog_len[0]++] = nop;
    prog[0][prog_len[0]++] = nop;
    prog[0][prog_len[0]++] = nop;
    // Filler so the directed phases of both instances run before random.
    while (prog_len[0] < prog_len[1]) prog[0][prog_len[0]++] = nop;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    wr_heavy = 1'b0;
    rst      = 1'b0;
    for (int k = 0; k < 2; k++) begin
      d_in[k] = '0;
      zero_e[k] = 1'b0; lt_e[k] = 1'b0; ltu_e[k] = 1'b0;
      last_flush_d[k] = 1'b0; last_flush_e[k] = 1'b0; last_stall_d[k] = 1'b0;
      for (int s = 0; s < 3; s++) st[k][s] = '0;
    end
    load_programs();

    run_cycles(2);
    rst = 1'b1;
    run_cycles(45);          // directed programs
    run_cycles(400);         // random traffic

    wr_heavy = 1'b1;         // fill the pipe with writes, then reset mid-stream
    run_cycles(6);
    rst = 1'b0;
    run_cycles(1);
    rst = 1'b1;
    wr_heavy = 1'b0;
    run_cycles(300);

    @(negedge clk);
    #1;
    check(0, "queue_drained", 8'(exp_q0.size()), 8'd0);
    check(1, "queue_drained", 8'(exp_q1.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
